// File: rtl/gate_tt_sequencer.sv
// -----------------------------------------------------------------------------
// gate_tt_sequencer
//
// Purpose:
//   Self-checking truth-table sequencer for basic-gate blocks. It drives every
//   input combination onto the gate under test and holds each one for HOLD
//   settle cycles. It then samples the gate output for one cycle and compares
//   it against the expected reduction function. It counts the mismatches and
//   flags a pass when the sweep completes with none.
//
// Parameters:
//   N_IN  number of gate inputs (1..4); the sweep covers 2**N_IN vectors
//   HOLD  settle cycles per vector before the sample cycle (>= 1)
//   GATE  expected function: 0=NOR 1=OR 2=AND 3=NAND 4=XOR 5=XNOR
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle sweep request, accepted only in IDLE or DONE
//   x          out  [N_IN-1:0] drive to the gate inputs (equals vec_idx)
//   t          in   gate output under test, compared only in SAMPLE
//   vec_idx    out  [N_IN-1:0] index of the current vector
//   busy       out  high from the first DRIVE cycle through the last SAMPLE
//   done       out  high in DONE until the next accepted start
//   pass       out  done && err_cnt == 0
//   err_cnt    out  [N_IN:0] mismatch count; tops out at 2**N_IN, never wraps
//   dbg_state  out  [1:0] FSM state: 0=IDLE 1=DRIVE 2=SAMPLE 3=DONE
//
// Optional feature (macro TT_FAIL_LOG_EN):
//   fail_vld   out  set by the first mismatch of a sweep
//   fail_idx   out  [N_IN-1:0] vector index of that first mismatch
//   Both are cleared by reset or by an accepted start.
//
// Handshake: start is a level sampled on the rising edge while the FSM is in
// IDLE or DONE. It has no ready signal. A start seen in DRIVE or SAMPLE is
// dropped with no side effects.
// -----------------------------------------------------------------------------
module gate_tt_sequencer #(
  parameter int N_IN = 2,
  parameter int HOLD = 4,
  parameter int GATE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            t,
  output logic [N_IN-1:0] vec_idx,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [1:0]      dbg_state
`ifdef TT_FAIL_LOG_EN
  ,
  output logic            fail_vld,
  output logic [N_IN-1:0] fail_idx
`endif
);

  localparam int              CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD - 1);
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] vec_q;
  logic [CW-1:0]   hold_q;
  logic [N_IN:0]   err_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic            expect_t;
  logic            mismatch;
  logic [N_IN:0]   err_inc;

  // Parameter legality is checked at elaboration so a bad GATE/N_IN/HOLD
  // never produces a silently wrong checker.
  if (N_IN < 1 || N_IN > 4 || HOLD < 1 || GATE < 0 || GATE > 5) begin : g_bad_param
    $error("gate_tt_sequencer: illegal parameters N_IN=%0d HOLD=%0d GATE=%0d",
           N_IN, HOLD, GATE);
  end

  // Expected gate output for the vector currently on x.
  if (GATE == 0) begin : g_nor
    assign expect_t = ~(|vec_q);
  end else if (GATE == 1) begin : g_or
    assign expect_t = |vec_q;
  end else if (GATE == 2) begin : g_and
    assign expect_t = &vec_q;
  end else if (GATE == 3) begin : g_nand
    assign expect_t = ~(&vec_q);
  end else if (GATE == 4) begin : g_xor
    assign expect_t = ^vec_q;
  end else begin : g_xnor
    assign expect_t = ~(^vec_q);
  end

  assign mismatch = (t != expect_t);
  // Count including the current sample; the DONE transition uses it so pass
  // reflects the last vector as well.
  assign err_inc  = err_q + (N_IN+1)'(mismatch);

`ifdef TT_FAIL_LOG_EN
  logic            fail_vld_q;
  logic [N_IN-1:0] fail_idx_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef TT_FAIL_LOG_EN
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_DRIVE;
            vec_q      <= '0;
            hold_q     <= '0;
            err_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef TT_FAIL_LOG_EN
            fail_vld_q <= 1'b0;
            fail_idx_q <= '0;
`endif
          end
        end

        ST_DRIVE: begin
          // x stays put while the gate settles; only the counter moves.
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            hold_q  <= hold_q + CW'(1);
          end
        end

        ST_SAMPLE: begin
          err_q <= err_inc;
`ifdef TT_FAIL_LOG_EN
          if (mismatch && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_idx_q <= vec_q;
          end
`endif
          if (vec_q == LAST_VEC) begin
            // x keeps the last vector through DONE.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_inc == '0);
          end else begin
            state_q <= ST_DRIVE;
            vec_q   <= vec_q + N_IN'(1);
            hold_q  <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign x         = vec_q;
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

`ifdef TT_FAIL_LOG_EN
  assign fail_vld  = fail_vld_q;
  assign fail_idx  = fail_idx_q;
`endif

endmodule
